// File: rtl/bram_port_arbiter_if.sv
// Bundle of the two client ports and the BRAM port A connection.
// slave = arbiter side, master = clients plus the memory itself.
interface bram_port_arbiter_if #(
    parameter int AW = 3,
    parameter int DW = 8
);
    logic          c0_req;
    logic          c0_we;
    logic [AW-1:0] c0_addr;
    logic [DW-1:0] c0_wdata;
    logic          c0_gnt;
    logic          c0_rvalid;
    logic [DW-1:0] c0_rdata;

    logic          c1_req;
    logic          c1_we;
    logic [AW-1:0] c1_addr;
    logic [DW-1:0] c1_wdata;
    logic          c1_gnt;
    logic          c1_rvalid;
    logic [DW-1:0] c1_rdata;

    logic          mem_ena;
    logic          mem_wea;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_din;
    logic [DW-1:0] mem_dout;

    modport slave (
        input  c0_req, c0_we, c0_addr, c0_wdata,
        output c0_gnt, c0_rvalid, c0_rdata,
        input  c1_req, c1_we, c1_addr, c1_wdata,
        output c1_gnt, c1_rvalid, c1_rdata,
        output mem_ena, mem_wea, mem_addr, mem_din,
        input  mem_dout
    );

    modport master (
        output c0_req, c0_we, c0_addr, c0_wdata,
        input  c0_gnt, c0_rvalid, c0_rdata,
        output c1_req, c1_we, c1_addr, c1_wdata,
        input  c1_gnt, c1_rvalid, c1_rdata,
        input  mem_ena, mem_wea, mem_addr, mem_din,
        output mem_dout
    );
endinterface

// File: rtl/bram_port_arbiter.sv
// Two-client round-robin arbiter in front of a single BRAM port,
// zero-filling the memory after reset or clear before arbitrating.
module bram_port_arbiter #(
    parameter int AW     = 3,
    parameter int DW     = 8,
    parameter int RD_LAT = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clear,
    output logic                init_done,
    bram_port_arbiter_if.slave  bus
);

    typedef enum logic {
        S_INIT,
        S_RUN
    } state_t;

    localparam logic [AW-1:0] LAST_ADDR = '1;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [AW-1:0]     r_cnt;
    logic [AW-1:0]     w_cnt_nxt;
    logic              r_rr_ptr;
    logic              w_rr_nxt;
    logic [RD_LAT-1:0] r_vld;
    logic [RD_LAT-1:0] r_id;

    logic              w_gnt0;
    logic              w_gnt1;
    logic              w_ena;
    logic              w_wea;
    logic [AW-1:0]     w_addr;
    logic [DW-1:0]     w_din;
    logic              w_rd;
    logic              w_rd_id;
    logic              w_ret;

    // State, fill counter and round-robin pointer registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_INIT;
            r_cnt    <= '0;
            r_rr_ptr <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_rr_ptr <= w_rr_nxt;
        end
    end

    // Next state, grant decision and BRAM port drive
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_rr_nxt    = r_rr_ptr;
        w_gnt0      = 1'b0;
        w_gnt1      = 1'b0;
        w_ena       = 1'b0;
        w_wea       = 1'b0;
        w_addr      = '0;
        w_din       = '0;
        if (!reset) begin
            unique case (r_state)
                S_INIT: begin
                    w_ena  = 1'b1;
                    w_wea  = 1'b1;
                    w_addr = r_cnt;
                    if (clear) begin
                        w_cnt_nxt = '0;
                    end else if (r_cnt == LAST_ADDR) begin
                        w_state_nxt = S_RUN;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
                S_RUN: begin
                    if (clear) begin
                        w_state_nxt = S_INIT;
                        w_cnt_nxt   = '0;
                    end else if (bus.c0_req &&
                                 (!bus.c1_req || !r_rr_ptr)) begin
                        w_gnt0   = 1'b1;
                        w_rr_nxt = 1'b1;
                        w_ena    = 1'b1;
                        w_wea    = bus.c0_we;
                        w_addr   = bus.c0_addr;
                        w_din    = bus.c0_wdata;
                    end else if (bus.c1_req) begin
                        w_gnt1   = 1'b1;
                        w_rr_nxt = 1'b0;
                        w_ena    = 1'b1;
                        w_wea    = bus.c1_we;
                        w_addr   = bus.c1_addr;
                        w_din    = bus.c1_wdata;
                    end
                end
                default: ;
            endcase
        end
    end

    assign w_rd    = (w_gnt0 & ~bus.c0_we) | (w_gnt1 & ~bus.c1_we);
    assign w_rd_id = w_gnt1;

    // Read-return tracker: valid bit and client id per latency stage
    always_ff @(posedge clk) begin
        if (reset) begin
            r_vld <= '0;
            r_id  <= '0;
        end else begin
            r_vld[0] <= w_rd;
            r_id[0]  <= w_rd_id;
            for (int i = 1; i < RD_LAT; i++) begin
                r_vld[i] <= r_vld[i-1];
                r_id[i]  <= r_id[i-1];
            end
        end
    end

    assign w_ret = r_vld[RD_LAT-1] & ~reset;

    assign bus.c0_gnt    = w_gnt0;
    assign bus.c1_gnt    = w_gnt1;
    assign bus.c0_rvalid = w_ret & ~r_id[RD_LAT-1];
    assign bus.c1_rvalid = w_ret &  r_id[RD_LAT-1];
    assign bus.c0_rdata  = bus.c0_rvalid ? bus.mem_dout : '0;
    assign bus.c1_rdata  = bus.c1_rvalid ? bus.mem_dout : '0;
    assign bus.mem_ena   = w_ena;
    assign bus.mem_wea   = w_wea;
    assign bus.mem_addr  = w_addr;
    assign bus.mem_din   = w_din;
    assign init_done     = (r_state == S_RUN) & ~reset;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Directed bench for bram_port_arbiter with a 2-cycle BRAM model.
// Inputs change 1 ns after the rising edge, outputs are checked 1 ns later.
module tb_bram_port_arbiter;

    localparam int AW = 3;
    localparam int DW = 8;
    localparam int RD_LAT = 2;

    localparam logic [7:0] C0A [6] = '{8'd0, 8'd2, 8'd2, 8'd4, 8'd4, 8'd6};
    localparam logic [7:0] C1A [6] = '{8'd1, 8'd1, 8'd3, 8'd3, 8'd5, 8'd5};
    localparam logic [7:0] ED  [6] = '{8'h11, 8'h3E, 8'h22, 8'h33, 8'h44, 8'h55};
    localparam logic [7:0] DA  [3] = '{8'd3, 8'd5, 8'd7};
    localparam logic [7:0] DD  [3] = '{8'h33, 8'h55, 8'h77};

    logic clk;
    logic reset;
    logic clear;
    logic init_done;
    int   n_vec;
    int   n_err;

    logic [DW-1:0] mem [8];
    logic [DW-1:0] d1;
    logic [DW-1:0] d2;

    bram_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    bram_port_arbiter #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT)) dut (
        .clk       (clk),
        .reset     (reset),
        .clear     (clear),
        .init_done (init_done),
        .bus       (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // BRAM model: registered read plus output register
    initial begin
        for (int i = 0; i < 8; i++) mem[i] = 8'hA0 + 8'(i);
        d1 = '0;
        d2 = '0;
    end
    always @(posedge clk) begin
        d2 = d1;
        if (bus.mem_ena) begin
            if (bus.mem_wea) mem[bus.mem_addr] = bus.mem_din;
            else d1 = mem[bus.mem_addr];
        end
    end
    assign bus.mem_dout = d2;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drv0(input logic r, input logic w,
                        input logic [7:0] a, input logic [7:0] d);
        bus.c0_req   = r;
        bus.c0_we    = w;
        bus.c0_addr  = a[AW-1:0];
        bus.c0_wdata = d;
    endtask

    task automatic drv1(input logic r, input logic w,
                        input logic [7:0] a, input logic [7:0] d);
        bus.c1_req   = r;
        bus.c1_we    = w;
        bus.c1_addr  = a[AW-1:0];
        bus.c1_wdata = d;
    endtask

    // Eight fill cycles; caller has already advanced into the first one
    task automatic fill_chk(input string tag);
        for (int k = 0; k < 8; k++) begin
            if (k > 0) tick();
            settle();
            chk({tag, "_addr"}, 32'(bus.mem_addr), k);
            chk({tag, "_ena"}, 32'(bus.mem_ena), 1);
            chk({tag, "_wea"}, 32'(bus.mem_wea), 1);
            chk({tag, "_din"}, 32'(bus.mem_din), 0);
            chk({tag, "_done"}, 32'(init_done), 0);
            chk({tag, "_gnt"}, {30'd0, bus.c1_gnt, bus.c0_gnt}, 0);
            chk({tag, "_rv"}, {30'd0, bus.c1_rvalid, bus.c0_rvalid}, 0);
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        reset = 1'b1;
        clear = 1'b0;
        drv0(1, 0, 3, 8'h12);
        drv1(1, 1, 4, 8'h34);

        // Reset with requests pending: everything quiet
        tick();
        settle();
        chk("rst_gnt", {30'd0, bus.c1_gnt, bus.c0_gnt}, 0);
        chk("rst_ena", 32'(bus.mem_ena), 0);
        chk("rst_wea", 32'(bus.mem_wea), 0);
        chk("rst_addr", 32'(bus.mem_addr), 0);
        chk("rst_din", 32'(bus.mem_din), 0);
        chk("rst_done", 32'(init_done), 0);
        chk("rst_rv", {30'd0, bus.c1_rvalid, bus.c0_rvalid}, 0);
        chk("rst_rd", {16'd0, bus.c1_rdata, bus.c0_rdata}, 0);
        tick();

        // Zero fill, c1 read held throughout
        tick();
        reset = 1'b0;
        drv0(0, 0, 0, 0);
        drv1(1, 0, 5, 0);
        fill_chk("fill");
        tick();
        settle();
        chk("run_done", 32'(init_done), 1);
        chk("run_gnt1", 32'(bus.c1_gnt), 1);
        chk("run_addr", 32'(bus.mem_addr), 5);
        tick();
        drv1(0, 0, 0, 0);
        settle();
        chk("run_rv1_early", 32'(bus.c1_rvalid), 0);
        tick();
        settle();
        chk("run_rv1", 32'(bus.c1_rvalid), 1);
        chk("run_rd1", 32'(bus.c1_rdata), 0);

        // Read back all locations with c0, one per cycle
        for (int k = 0; k < 10; k++) begin
            tick();
            drv0(k < 8, 0, 8'(k), 0);
            settle();
            chk("rb_gnt0", 32'(bus.c0_gnt), (k < 8) ? 1 : 0);
            if (k < 8) chk("rb_addr", 32'(bus.mem_addr), k);
            if (k >= 2) begin
                chk("rb_rv0", 32'(bus.c0_rvalid), 1);
                chk("rb_rd0", 32'(bus.c0_rdata), 0);
            end
            chk("rb_rv1", 32'(bus.c1_rvalid), 0);
        end

        // Both write with pointer at c1
        tick();
        drv0(1, 1, 0, 8'h11);
        drv1(1, 1, 7, 8'h77);
        settle();
        chk("rr_gnt1", {30'd0, bus.c1_gnt, bus.c0_gnt}, 2);
        chk("rr_addr", 32'(bus.mem_addr), 7);
        chk("rr_din", 32'(bus.mem_din), 8'h77);
        chk("rr_wea", 32'(bus.mem_wea), 1);
        tick();
        drv1(0, 0, 0, 0);
        settle();
        chk("rr_gnt0", {30'd0, bus.c1_gnt, bus.c0_gnt}, 1);
        chk("rr_din0", 32'(bus.mem_din), 8'h11);

        // c0 writes 0x3E to 1, c1 reads it back
        tick();
        drv0(1, 1, 1, 8'h3E);
        settle();
        chk("wr_gnt0", 32'(bus.c0_gnt), 1);
        chk("wr_din", 32'(bus.mem_din), 8'h3E);
        tick();
        drv0(0, 0, 0, 0);
        drv1(1, 0, 1, 0);
        settle();
        chk("rd_gnt1", {30'd0, bus.c1_gnt, bus.c0_gnt}, 2);
        chk("rd_wea", 32'(bus.mem_wea), 0);
        tick();
        drv1(0, 0, 0, 0);
        settle();
        chk("rd_rv1_early", 32'(bus.c1_rvalid), 0);
        tick();
        settle();
        chk("rd_rv1", 32'(bus.c1_rvalid), 1);
        chk("rd_rd1", 32'(bus.c1_rdata), 8'h3E);
        chk("rd_rv0", 32'(bus.c0_rvalid), 0);

        // c1 writes k*0x11 to addresses 2..6
        for (int k = 2; k < 7; k++) begin
            tick();
            drv1(1, 1, 8'(k), 8'(k * 17));
            settle();
            chk("wk_gnt1", 32'(bus.c1_gnt), 1);
        end

        // Both read continuously: grants alternate, returns in order
        for (int j = 0; j < 8; j++) begin
            tick();
            if (j < 6) begin
                drv0(1, 0, C0A[j], 0);
                drv1(1, 0, C1A[j], 0);
            end else begin
                drv0(0, 0, 0, 0);
                drv1(0, 0, 0, 0);
            end
            settle();
            if (j < 6) begin
                chk("alt_gnt", {30'd0, bus.c1_gnt, bus.c0_gnt},
                    (j % 2 == 0) ? 1 : 2);
                chk("alt_addr", 32'(bus.mem_addr), j);
            end
            if (j >= 2) begin
                chk("alt_rv", {30'd0, bus.c1_rvalid, bus.c0_rvalid},
                    ((j - 2) % 2 == 0) ? 1 : 2);
                chk("alt_rd", {16'd0, bus.c1_rdata, bus.c0_rdata},
                    ((j - 2) % 2 == 0) ? 32'(ED[j-2]) : {16'd0, ED[j-2], 8'd0});
            end
        end

        // Reads to 3,5,7 then clear with c0 pending; in-flight reads land
        for (int t = 0; t < 15; t++) begin
            tick();
            clear = (t == 3);
            if (t < 3) drv0(1, 0, DA[t], 0);
            else if (t < 13) drv0(1, 0, 6, 0);
            else drv0(0, 0, 0, 0);
            settle();
            if (t < 3) begin
                chk("cl_gnt", 32'(bus.c0_gnt), 1);
                chk("cl_addr", 32'(bus.mem_addr), DA[t]);
            end else if (t == 3) begin
                chk("cl_nognt", 32'(bus.c0_gnt), 0);
                chk("cl_ena", 32'(bus.mem_ena), 0);
                chk("cl_done", 32'(init_done), 1);
            end else if (t < 12) begin
                chk("cl_fgnt", 32'(bus.c0_gnt), 0);
                chk("cl_faddr", 32'(bus.mem_addr), t - 4);
                chk("cl_fdone", 32'(init_done), 0);
            end else if (t == 12) begin
                chk("cl_rdone", 32'(init_done), 1);
                chk("cl_rgnt", 32'(bus.c0_gnt), 1);
                chk("cl_raddr", 32'(bus.mem_addr), 6);
            end
            chk("cl_rv0", 32'(bus.c0_rvalid),
                (t >= 2 && t <= 4) || t == 14 ? 1 : 0);
            if (t >= 2 && t <= 4) chk("cl_rd0", 32'(bus.c0_rdata), DD[t-2]);
            if (t == 14) chk("cl_rd0z", 32'(bus.c0_rdata), 0);
        end
        clear = 1'b0;

        // Clear during fill restarts the counter
        tick();
        clear = 1'b1;
        settle();
        chk("ci_ena", 32'(bus.mem_ena), 0);
        tick();
        clear = 1'b0;
        settle();
        chk("ci_a0", 32'(bus.mem_addr), 0);
        tick();
        settle();
        chk("ci_a1", 32'(bus.mem_addr), 1);
        tick();
        clear = 1'b1;
        settle();
        chk("ci_a2", 32'(bus.mem_addr), 2);
        chk("ci_wea", 32'(bus.mem_wea), 1);
        tick();
        clear = 1'b0;
        fill_chk("ci");
        tick();
        settle();
        chk("ci_done", 32'(init_done), 1);

        // Reset one cycle after a c1 read grant drops the return
        tick();
        drv1(1, 0, 2, 0);
        settle();
        chk("mr_gnt1", 32'(bus.c1_gnt), 1);
        tick();
        reset = 1'b1;
        drv0(1, 1, 3, 8'hAA);
        drv1(1, 0, 4, 0);
        settle();
        chk("mr_gnt", {30'd0, bus.c1_gnt, bus.c0_gnt}, 0);
        chk("mr_ena", 32'(bus.mem_ena), 0);
        chk("mr_addr", 32'(bus.mem_addr), 0);
        chk("mr_din", 32'(bus.mem_din), 0);
        chk("mr_done", 32'(init_done), 0);
        chk("mr_rv", {30'd0, bus.c1_rvalid, bus.c0_rvalid}, 0);
        tick();
        reset = 1'b0;
        drv0(0, 0, 0, 0);
        drv1(0, 0, 0, 0);
        fill_chk("mr");
        tick();
        settle();
        chk("mr_rdone", 32'(init_done), 1);

        // Reset returns the round-robin pointer to c0
        tick();
        drv0(1, 1, 0, 8'h05);
        settle();
        chk("rp_gnt0", 32'(bus.c0_gnt), 1);
        tick();
        reset = 1'b1;
        drv0(0, 0, 0, 0);
        settle();
        tick();
        reset = 1'b0;
        drv0(1, 0, 0, 0);
        drv1(1, 0, 1, 0);
        fill_chk("rp");
        tick();
        settle();
        chk("rp_both", {30'd0, bus.c1_gnt, bus.c0_gnt}, 1);
        tick();
        drv0(0, 0, 0, 0);
        settle();
        chk("rp_next", {30'd0, bus.c1_gnt, bus.c0_gnt}, 2);
        tick();
        drv1(0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/bram_port_arbiter.md
BRAM_PORT_ARBITER -- requirements
Module: bram_port_arbiter

Interface
REQ-001 The block SHALL have parameter AW, default 3, meaning the BRAM address width (DEPTH = 2**AW).
REQ-002 The block SHALL have parameter DW, default 8, meaning the BRAM data width.
REQ-003 The block SHALL have parameter RD_LAT, default 1, meaning the BRAM read latency in clk cycles (legal 1..2).
REQ-004 The block SHALL have port clk, input, 1, the clock; all state updates on the rising edge.
REQ-005 The block SHALL have port reset, input, 1, reset: synchronous, active-high.
REQ-006 The block SHALL have port clear, input, 1, a single-cycle pulse that restarts the zero-fill sequence.
REQ-007 The block SHALL have ports c0_req/c1_req, input, 1, the client access request, held until granted.
REQ-008 The block SHALL have ports c0_we/c1_we, input, 1, meaning 1 = write and 0 = read; stable while req is high.
REQ-009 The block SHALL have ports c0_addr/c1_addr, input, AW, the client address; stable while req is high.
REQ-010 The block SHALL have ports c0_wdata/c1_wdata, input, DW, the client write data; stable while req is high.
REQ-011 The block SHALL have ports c0_gnt/c1_gnt, output, 1, meaning the access is accepted at this rising edge.
REQ-012 The block SHALL have ports c0_rvalid/c1_rvalid, output, 1, meaning read data is valid this cycle.
REQ-013 The block SHALL have ports c0_rdata/c1_rdata, output, DW, the read data, forced to 0 when rvalid is low.
REQ-014 The block SHALL have port init_done, output, 1, meaning the zero-fill is complete and arbitration is active.
REQ-015 The block SHALL have ports mem_ena, mem_wea, mem_addr[AW], mem_din[DW], outputs, the BRAM port A controls.
REQ-016 The block SHALL have port mem_dout, input, DW, the BRAM port A read data.

Function
REQ-017 FSM states SHALL be INIT and RUN; reset or clear SHALL enter INIT with init counter = 0.
REQ-018 In INIT, each cycle SHALL drive mem_ena=1, mem_wea=1, mem_addr=counter, mem_din=0 and increment counter; gnt outputs SHALL be 0.
REQ-019 After the write to address DEPTH-1, the FSM SHALL move to RUN; init_done SHALL be 1 in exactly the RUN state; fill takes DEPTH cycles.
REQ-020 In RUN with exactly one req high, that client SHALL be granted in the same cycle (combinational gnt, zero-latency).
REQ-021 In RUN with both req high, the client selected by rr_ptr SHALL be granted; rr_ptr SHALL reset to 0.
REQ-022 After any grant, rr_ptr SHALL point to the non-granted client; rr_ptr SHALL be unchanged in cycles with no grant.
REQ-023 At most one gnt SHALL be high per cycle.
REQ-024 On a grant, mem_ena=1, mem_wea=we, mem_addr=addr and mem_din=wdata SHALL be driven from the granted client in that cycle; with no grant, mem_ena=0, mem_wea=0, and mem_addr/mem_din=0.
REQ-025 A read granted at edge N SHALL produce rvalid=1 on that client for exactly one cycle, RD_LAT cycles later, with rdata=mem_dout, using a RD_LAT-deep valid+client-id shift register.
REQ-026 Writes SHALL never produce rvalid.
REQ-027 Back-to-back reads SHALL be sustained at one per cycle, with returns in grant order.
REQ-028 A clear seen in RUN SHALL take priority over requests: no grant in that cycle, and INIT starts next cycle.
REQ-029 Read returns already in flight when clear is seen SHALL still be delivered.
REQ-030 A clear seen during INIT SHALL restart the counter at 0.
REQ-031 Address wrap SHALL be impossible: the INIT counter stops at DEPTH-1, and client addresses are AW bits wide.

Reset
REQ-032 While reset is high, gnt, rvalid, rdata, init_done and all mem_* outputs SHALL be 0, the shift register SHALL be cleared, and rr_ptr SHALL be 0.
REQ-033 Reset asserted mid-operation SHALL discard in-flight reads (no rvalid after reset) and restart INIT after deassertion.
REQ-034 The first INIT write SHALL occur in the first cycle after reset deasserts.

Verification
REQ-035 Scenario: reset, then idle -> 8 writes of 0 to addresses 0..7 on consecutive cycles, then init_done=1 on the 9th cycle; every location then reads 0.
REQ-036 Scenario: c0 writes 0x3E to address 1, then c1 reads address 1 -> c1_gnt in the same cycle as c1_req; c1_rvalid RD_LAT cycles later with c1_rdata=0x3E; c0_rvalid stays 0.
REQ-037 Scenario: c0 and c1 request reads continuously for 6 cycles -> grants alternate c0,c1,c0,c1,c0,c1; each client gets 3 rvalids in order.
REQ-038 Scenario: clear pulsed in the same cycle as c0_req -> no grant; init_done falls; 8 fill cycles follow; c0 granted on the first RUN cycle.
REQ-039 Scenario: reset asserted one cycle after a c1 read grant (RD_LAT=2) -> no c1_rvalid ever appears; all outputs 0 during reset.
REQ-040 Scenario: RD_LAT=2 with reads to addresses 3,5,7 on consecutive cycles -> rvalid on cycles +2,+3,+4 with the matching data.
